spi_mem_arbiter: RTL and testbench
==================================

Name: spi_mem_arbiter

Overview:
- Two-port word-level front end for the serial SPI RAM/ROM bus.
- Arbitrates between requester 0 (CPU core) and requester 1 (UART loader/debug port).
- Sequences one complete 84-clock SPI frame per granted request, then returns read data with a one-cycle done pulse.
- Sits between the requesters and io_out[3:0]; it owns CS0/CS1/SCLK/MOSI exclusively.

Parameters:
- CMD_READ, 8'h03, command byte sent for reads.
- CMD_WRITE, 8'h02, command byte sent for writes.
- FAIR, 1, 1 = round-robin between the two ports; 0 = fixed priority, port 0 wins.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. Single clock; reset is synchronous and active-low.
- req  in  2  per-port request, level; held until that port's done.
- rnw  in  2  per-port 1 = read, 0 = write.
- addr  in  32  per-port 16-bit word address, {addr1,addr0}; bit 15 selects the chip.
- wdata  in  32  per-port write word, {wdata1,wdata0}.
- gnt  out  2  one-hot; which port owns the frame in progress.
- done  out  2  one-cycle pulse on the owning port at end of frame.
- rdata  out  16  read word; valid in the done cycle, held until the next done.
- busy  out  1  frame in progress.
- spi_cs0  out  1  RAM select, active-low (addr[15]=0).
- spi_cs1  out  1  ROM select, active-low (addr[15]=1).
- spi_clk  out  1  SPI clock.
- spi_mosi  out  1  SPI data to memory.
- spi_miso  in  1  SPI data from memory.

Behaviour:
- Reset (rst_n=0 at a clk edge), outputs and state:
  - gnt=0, done=0, rdata=0, busy=0, spi_cs0=spi_cs1=1, spi_clk=0, spi_mosi=0.
  - FSM returns to IDLE; round-robin pointer favours port 0.
- Reset mid-frame aborts the frame. Chip selects rise on the reset edge. No done is issued.
- All SPI outputs are registered, and every output changes only on clk rising edges.
- FSM states: IDLE -> GUARD -> CMD -> ADDR -> DATA -> TAIL -> IDLE.
- IDLE:
  - If any req bit is set, the arbiter picks a port.
  - Request fields are latched into internal rnw_l/addr_l/shreg in the same edge, and gnt is set.
  - Next state is GUARD.
  - Requester inputs are ignored for the rest of the frame.
- Arbitration:
  - FAIR=1: on simultaneous requests, the port not granted last wins.
  - FAIR=0: port 0 always wins.
  - Single request: granted immediately. Grant latency from req rise in IDLE is 1 clk.
- Bit timing: each SPI bit occupies 2 clks.
  - First clk: spi_clk=0, spi_mosi=bit.
  - Second clk: spi_clk=1.
  - spi_miso is sampled at the edge that ends the spi_clk=1 cycle.
- GUARD: 2 clks with both CS high. This enforces minimum CS-high time between frames.
- CMD: 8 bits, 16 clks.
  - The selected CS goes low at CMD entry: cs0=addr_l[15], cs1=!addr_l[15].
  - Byte is CMD_READ or CMD_WRITE, MSB first.
- ADDR: 16 bits, 32 clks. addr_l[0] first through addr_l[14], then a constant 0 (byte-address LSB).
- DATA: 16 bits, 32 clks.
  - Write: shreg[0] is driven first, LSB first.
  - Read: mosi=0; miso is shifted into shreg MSB-in, so the first bit received lands in rdata[0].
- TAIL: 2 clks.
  - spi_clk=0 and CS still low in the first clk.
  - CS goes high in the second clk; done[gnt] pulses and rdata updates (reads only) in that clk.
  - gnt and busy clear on the following edge.
- Total frame: 84 clks from GUARD entry to the IDLE return. Back-to-back requests therefore start a new GUARD immediately after IDLE (1 idle clk).
- Writes do not alter rdata.
- A port dropping req mid-frame is legal: the frame completes and done still pulses.
- A port asserting req during another port's frame is granted at the next IDLE if it is still asserted.
- Counters:
  - 7-bit phase counter, wrapping 0..83; never exceeds 83.
  - 5-bit bit counter within each field.

Decomposition:
- Shared package spi_mem_pkg, containing:
  - FSM state enum (IDLE, GUARD, CMD, ADDR, DATA, TAIL);
  - CMD_READ/CMD_WRITE defaults;
  - field lengths: GUARD=2, CMD=8, ADDR=16, DATA=16 bits;
  - FRAME_CLKS=84.
- One sub-module: spi_rr_arb2, the 2-way round-robin/fixed arbiter with pointer update on grant.
- The frame sequencer and shift register stay in the top.

Test Plan:
- Single read:
  - Stimulus: port0 req, rnw=1, addr=16'h8001; memory model returns 16'hBEEF.
  - Response: cs1 low and cs0 high for the frame.
  - MOSI bits: 0000_0011; then address 1,0,...,0 (bit15 last sent 0, then 0); data bits all 0.
  - done[0] at clk 84; rdata=16'hBEEF.
- Single write:
  - Stimulus: port1, rnw=0, addr=16'h0010, wdata=16'h00A5.
  - Response: cs0 low; command 0x02; data bits on MOSI 1,0,1,0,0,1,0,1,0...; done[1]=1 and rdata unchanged.
- Simultaneous requests, FAIR=1:
  - Stimulus: both ports request 3 frames each.
  - Response: grant order 0,1,0,1,0,1; each done 85 clks apart.
  - With FAIR=0, port 0 wins every time while held.
- Reset mid-frame:
  - Stimulus: rst_n=0 at phase 40 of a read.
  - Response: next edge has cs0=cs1=1, spi_clk=0, gnt=0, busy=0; no done pulse.
  - After rst_n=1, a new request gets a full 84-clk frame.
- Request withdrawn:
  - Stimulus: port0 drops req at clk 10.
  - Response: frame completes, done[0] pulses, no second grant.
- Phase-counter wrap:
  - Stimulus: 100 back-to-back reads.
  - Response: SCLK count is exactly 40 rising edges per frame; CS high for at least 2 clks between frames.

Source files
------------

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory front end.
// Frame layout: GUARD(2) CMD(16) ADDR(32) DATA(32) TAIL(2) clks.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GUARD,
    CMD,
    ADDR,
    DATA,
    TAIL
  } state_t;

  localparam logic [7:0] DEF_CMD_READ  = 8'h03;
  localparam logic [7:0] DEF_CMD_WRITE = 8'h02;

  localparam int GUARD_CLKS = 2;
  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 16;
  localparam int DATA_BITS  = 16;
  localparam int FRAME_CLKS = 84;

  // Word address goes out LSB first; the 16th bit is the byte-address LSB.
  function automatic logic addr_bit(
    input logic [15:0] a,
    input logic [4:0]  b
  );
    return (b < 5'd15) ? a[b[3:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/spi_mem_arbiter_if.sv
// Requester-side bus of the SPI memory arbiter.
// Ports are packed {port1, port0}.
interface spi_mem_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  rnw;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [15:0] rdata;
  logic        busy;

  modport master (
    output req, rnw, addr, wdata,
    input  gnt, done, rdata, busy
  );

  modport slave (
    input  req, rnw, addr, wdata,
    output gnt, done, rdata, busy
  );
endinterface

// File: rtl/spi_rr_arb2.sv
// Two-way arbiter: round-robin when FAIR!=0, else port 0 wins.
// Pointer moves only when a grant is taken.
module spi_rr_arb2 #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] pick
);

  logic ptr;

  always_comb begin
    pick = req;
    if (req == 2'b11)
      pick = (FAIR != 0 && ptr) ? 2'b10 : 2'b01;
  end

  // ptr=1 favours port 1 on the next tie.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= 1'b0;
    else if (take && |pick)
      ptr <= pick[0];
  end

endmodule

// File: rtl/spi_mem_arbiter.sv
// Two-port word front end for the SPI RAM/ROM bus.
// One 84-clk frame per grant; all outputs registered.
module spi_mem_arbiter
  import spi_mem_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = DEF_CMD_READ,
  parameter logic [7:0] CMD_WRITE = DEF_CMD_WRITE,
  parameter int         FAIR      = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_mem_arbiter_if.slave   bus,
  output logic               spi_cs0,
  output logic               spi_cs1,
  output logic               spi_clk,
  output logic               spi_mosi,
  input  logic               spi_miso
);

  state_t      st;
  logic [6:0]  ph;
  logic [4:0]  bcnt;
  logic        rnw_l;
  logic [15:0] addr_l;
  logic [15:0] shreg;
  logic [1:0]  pick;
  logic [7:0]  cmd;
  logic [1:0]  gnt_q;
  logic [1:0]  done_q;
  logic [15:0] rdata_q;
  logic        busy_q;

  assign cmd       = rnw_l ? CMD_READ : CMD_WRITE;
  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

  spi_rr_arb2 #(.FAIR(FAIR)) u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus.req),
    .take (st == IDLE),
    .pick (pick)
  );

  // Odd phases are the spi_clk=1 half; field starts are all even.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st       <= IDLE;
      ph       <= '0;
      bcnt     <= '0;
      rnw_l    <= 1'b0;
      addr_l   <= '0;
      shreg    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      spi_cs0  <= 1'b1;
      spi_cs1  <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      done_q <= '0;
      if (st != IDLE)
        ph <= (ph == 7'(FRAME_CLKS - 1)) ? '0 : ph + 7'd1;
      unique case (st)
        IDLE: begin
          if (|bus.req) begin
            gnt_q  <= pick;
            busy_q <= 1'b1;
            rnw_l  <= bus.rnw[pick[1]];
            addr_l <= pick[1] ? bus.addr[31:16] : bus.addr[15:0];
            shreg  <= pick[1] ? bus.wdata[31:16] : bus.wdata[15:0];
            ph     <= '0;
            st     <= GUARD;
          end
        end
        GUARD: begin
          if (ph == 7'(GUARD_CLKS - 1)) begin
            st       <= CMD;
            bcnt     <= '0;
            spi_cs0  <= addr_l[15];
            spi_cs1  <= !addr_l[15];
            spi_mosi <= cmd[7];
          end
        end
        CMD: begin
          if (!ph[0]) begin
            spi_clk <= 1'b1;
          end else begin
            spi_clk <= 1'b0;
            if (bcnt == 5'(CMD_BITS - 1)) begin
              st       <= ADDR;
              bcnt     <= '0;
              spi_mosi <= addr_l[0];
            end else begin
              bcnt     <= bcnt + 5'd1;
              spi_mosi <= cmd[3'd6 - bcnt[2:0]];
            end
          end
        end
        ADDR: begin
          if (!ph[0]) begin
            spi_clk <= 1'b1;
          end else begin
            spi_clk <= 1'b0;
            if (bcnt == 5'(ADDR_BITS - 1)) begin
              st       <= DATA;
              bcnt     <= '0;
              spi_mosi <= !rnw_l & shreg[0];
            end else begin
              bcnt     <= bcnt + 5'd1;
              spi_mosi <= addr_bit(addr_l, bcnt + 5'd1);
            end
          end
        end
        DATA: begin
          if (!ph[0]) begin
            spi_clk <= 1'b1;
          end else begin
            // Writes shift out of bit 0; reads shift miso in at bit 15.
            spi_clk <= 1'b0;
            shreg   <= {rnw_l & spi_miso, shreg[15:1]};
            if (bcnt == 5'(DATA_BITS - 1)) begin
              st       <= TAIL;
              spi_mosi <= 1'b0;
            end else begin
              bcnt     <= bcnt + 5'd1;
              spi_mosi <= !rnw_l & shreg[1];
            end
          end
        end
        TAIL: begin
          if (!ph[0]) begin
            spi_cs0 <= 1'b1;
            spi_cs1 <= 1'b1;
            done_q  <= gnt_q;
            if (rnw_l)
              rdata_q <= shreg;
          end else begin
            st     <= IDLE;
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Directed bench for spi_mem_arbiter with a small SPI memory model.
// Second instance runs fixed priority.
module tb_spi_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_mem_arbiter_if bus ();
  spi_mem_arbiter_if bus2 ();

  logic cs0, cs1, sclk, mosi;
  logic miso = 1'b0;
  logic f_cs0, f_cs1, f_sclk, f_mosi;

  spi_mem_arbiter #(.FAIR(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .spi_cs0 (cs0),
    .spi_cs1 (cs1),
    .spi_clk (sclk),
    .spi_mosi(mosi),
    .spi_miso(miso)
  );

  spi_mem_arbiter #(.FAIR(0)) dut_fix (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus2.slave),
    .spi_cs0 (f_cs0),
    .spi_cs1 (f_cs1),
    .spi_clk (f_sclk),
    .spi_mosi(f_mosi),
    .spi_miso(1'b0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] mem_data = 16'h0000;
  logic [39:0] cap = '0;
  int bitn = 0;
  int sclk_cnt = 0;
  logic sel;
  assign sel = ~(cs0 & cs1);

  always @(posedge sel) begin
    bitn = 0;
    sclk_cnt = 0;
    cap = '0;
  end

  always @(posedge sclk) begin
    if (bitn < 40) cap[bitn] = mosi;
    if (bitn >= 24 && bitn < 40) miso = mem_data[bitn-24];
    bitn++;
    sclk_cnt++;
  end

  int lo0 = 0, lo1 = 0, hi_run = 0, min_hi = 1000;
  always @(negedge clk) begin
    if (!cs0) lo0++;
    if (!cs1) lo1++;
    if (cs0 && cs1) hi_run++;
    else begin
      if (hi_run > 0 && hi_run < min_hi) min_hi = hi_run;
      hi_run = 0;
    end
  end

  task automatic wait_done(output int n, output logic [1:0] d);
    n = -1;
    d = 2'b00;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done != 2'b00) begin
        n = i;
        d = bus.done;
        break;
      end
    end
  endtask

  task automatic wait_done2(output int n, output logic [1:0] d);
    n = -1;
    d = 2'b00;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus2.done != 2'b00) begin
        n = i;
        d = bus2.done;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 2'b00 || bus.done !== 2'b00 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctl: gnt=%b done=%b busy=%b want 00 00 0",
               bus.gnt, bus.done, bus.busy);
    end
    n_cmp++;
    if (bus.rdata !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_rdata: got %h want 0000", bus.rdata);
    end
    n_cmp++;
    if ({cs0, cs1, sclk, mosi} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_spi: cs0,cs1,clk,mosi=%b want 1100",
               {cs0, cs1, sclk, mosi});
    end
    n_cmp++;
    if ({f_cs0, f_cs1, bus2.gnt} !== 4'b1100) begin
      n_bad++;
      $display("FAIL reset_fix: cs,gnt=%b want 1100", {f_cs0, f_cs1, bus2.gnt});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    int n, l0, l1;
    logic [1:0] d;
    l0 = lo0;
    l1 = lo1;
    bus.rnw = 2'b01;
    bus.addr = 32'h0000_8001;
    mem_data = 16'hBEEF;
    bus.req = 2'b01;
    wait_done(n, d);
    bus.req = 2'b00;
    n_cmp++;
    if (n !== 84 || d !== 2'b01) begin
      n_bad++;
      $display("FAIL read_done: lat=%0d done=%b want 84 01", n, d);
    end
    n_cmp++;
    if (bus.gnt !== 2'b01 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL read_gnt: gnt=%b busy=%b want 01 1", bus.gnt, bus.busy);
    end
    n_cmp++;
    if (bus.rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL read_rdata: got %h want beef", bus.rdata);
    end
    n_cmp++;
    if (cap !== 40'h00_0000_01C0) begin
      n_bad++;
      $display("FAIL read_mosi: got %h want 00000001c0", cap);
    end
    n_cmp++;
    if (sclk_cnt !== 40) begin
      n_bad++;
      $display("FAIL read_sclk: got %0d want 40", sclk_cnt);
    end
    n_cmp++;
    if (lo0 - l0 !== 0 || lo1 - l1 !== 81) begin
      n_bad++;
      $display("FAIL read_cs: cs0 low %0d cs1 low %0d want 0 81",
               lo0 - l0, lo1 - l1);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.done !== 2'b00) begin
      n_bad++;
      $display("FAIL read_end: gnt=%b busy=%b done=%b want 00 0 00",
               bus.gnt, bus.busy, bus.done);
    end
  endtask

  task automatic test_write;
    int n, l0, l1;
    logic [1:0] d;
    l0 = lo0;
    l1 = lo1;
    bus.rnw = 2'b00;
    bus.addr = 32'h0010_0000;
    bus.wdata = 32'h00A5_0000;
    bus.req = 2'b10;
    wait_done(n, d);
    bus.req = 2'b00;
    n_cmp++;
    if (n !== 84 || d !== 2'b10) begin
      n_bad++;
      $display("FAIL write_done: lat=%0d done=%b want 84 10", n, d);
    end
    n_cmp++;
    if (bus.rdata !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL write_rdata: got %h want beef", bus.rdata);
    end
    n_cmp++;
    if (cap !== 40'h00_A500_1040) begin
      n_bad++;
      $display("FAIL write_mosi: got %h want 00a5001040", cap);
    end
    n_cmp++;
    if (lo0 - l0 !== 81 || lo1 - l1 !== 0) begin
      n_bad++;
      $display("FAIL write_cs: cs0 low %0d cs1 low %0d want 81 0",
               lo0 - l0, lo1 - l1);
    end
    @(negedge clk);
  endtask

  task automatic test_fair;
    int n, c0, c1;
    logic [1:0] d, want;
    c0 = 0;
    c1 = 0;
    bus.rnw = 2'b11;
    bus.addr = 32'h0002_0002;
    mem_data = 16'h0F0F;
    bus.req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      wait_done(n, d);
      want = (k % 2 == 0) ? 2'b01 : 2'b10;
      n_cmp++;
      if (d !== want || n !== ((k == 0) ? 84 : 85)) begin
        n_bad++;
        $display("FAIL fair_%0d: done=%b lat=%0d want %b %0d",
                 k, d, n, want, (k == 0) ? 84 : 85);
      end
      if (n < 0) break;
      if (d[0]) c0++;
      if (d[1]) c1++;
      if (c0 >= 3) bus.req[0] = 1'b0;
      if (c1 >= 3) bus.req[1] = 1'b0;
    end
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.gnt !== 2'b00) begin
      n_bad++;
      $display("FAIL fair_idle: gnt=%b want 00", bus.gnt);
    end
  endtask

  task automatic test_fixed;
    int n;
    logic [1:0] d;
    bus2.rnw = 2'b11;
    bus2.addr = 32'h0001_0001;
    bus2.req = 2'b11;
    for (int k = 0; k < 3; k++) begin
      wait_done2(n, d);
      n_cmp++;
      if (d !== 2'b01 || n !== ((k == 0) ? 84 : 85)) begin
        n_bad++;
        $display("FAIL fixed_%0d: done=%b lat=%0d want 01", k, d, n);
      end
      if (n < 0) break;
    end
    bus2.req = 2'b10;
    wait_done2(n, d);
    bus2.req = 2'b00;
    n_cmp++;
    if (d !== 2'b10 || n !== 85) begin
      n_bad++;
      $display("FAIL fixed_p1: done=%b lat=%0d want 10 85", d, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int n, seen;
    logic [1:0] d;
    bus.rnw = 2'b01;
    bus.addr = 32'h0000_0005;
    mem_data = 16'h1234;
    bus.req = 2'b01;
    repeat (41) @(negedge clk);
    n_cmp++;
    if (cs0 !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_active: cs0=%b busy=%b want 0 1", cs0, bus.busy);
    end
    rst_n = 1'b0;
    bus.req = 2'b00;
    @(negedge clk);
    n_cmp++;
    if ({cs0, cs1, sclk, bus.gnt, bus.busy, bus.done} !== 8'b1100_0000) begin
      n_bad++;
      $display("FAIL mid_reset: cs0,cs1,clk,gnt,busy,done=%b want 11000000",
               {cs0, cs1, sclk, bus.gnt, bus.busy, bus.done});
    end
    rst_n = 1'b1;
    seen = 0;
    repeat (90) begin
      @(negedge clk);
      if (bus.done !== 2'b00) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++;
      $display("FAIL mid_nodone: %0d done cycles want 0", seen);
    end
    bus.req = 2'b01;
    wait_done(n, d);
    bus.req = 2'b00;
    n_cmp++;
    if (n !== 84 || d !== 2'b01 || bus.rdata !== 16'h1234 || sclk_cnt !== 40) begin
      n_bad++;
      $display("FAIL mid_after: lat=%0d done=%b rdata=%h sclk=%0d want 84 01 1234 40",
               n, d, bus.rdata, sclk_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_withdraw;
    int n, g;
    logic [1:0] d;
    bus.rnw = 2'b01;
    bus.addr = 32'h0000_0003;
    mem_data = 16'h5A5A;
    bus.req = 2'b01;
    repeat (10) @(negedge clk);
    bus.req = 2'b00;
    wait_done(n, d);
    n_cmp++;
    if (n !== 74 || d !== 2'b01 || bus.rdata !== 16'h5A5A) begin
      n_bad++;
      $display("FAIL withdraw_done: lat=%0d done=%b rdata=%h want 74 01 5a5a",
               n, d, bus.rdata);
    end
    g = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.gnt !== 2'b00) g++;
    end
    n_cmp++;
    if (g !== 0) begin
      n_bad++;
      $display("FAIL withdraw_regrant: %0d gnt cycles want 0", g);
    end
  endtask

  task automatic test_back_to_back;
    int n, frames, errs;
    logic [1:0] d;
    frames = 0;
    errs = 0;
    bus.rnw = 2'b01;
    bus.addr = 32'h0000_0100;
    mem_data = 16'hC3C3;
    bus.req = 2'b01;
    for (int k = 1; k <= 100; k++) begin
      wait_done(n, d);
      if (n < 0) break;
      frames++;
      if (n != ((k == 1) ? 84 : 85) || d != 2'b01 ||
          sclk_cnt != 40 || bus.rdata != 16'hC3C3)
        errs++;
      if (k == 100) bus.req = 2'b00;
    end
    bus.req = 2'b00;
    n_cmp++;
    if (frames !== 100 || errs !== 0) begin
      n_bad++;
      $display("FAIL b2b_frames: frames=%0d bad=%0d want 100 0", frames, errs);
    end
    n_cmp++;
    if (min_hi !== 4) begin
      n_bad++;
      $display("FAIL b2b_cs_high: min gap %0d want 4", min_hi);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req = 2'b00;
    bus.rnw = 2'b00;
    bus.addr = '0;
    bus.wdata = '0;
    bus2.req = 2'b00;
    bus2.rnw = 2'b00;
    bus2.addr = '0;
    bus2.wdata = '0;
    test_reset;
    test_read;
    test_write;
    test_fair;
    test_fixed;
    test_reset_mid;
    test_withdraw;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
